// File: rtl/cva6_pma_table.sv
// cva6_pma_table: runtime-programmable PMA table with a two-stage back-pressured lookup pipeline
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   cfg_*                     config access: word index = region*4 + field
//                             field 0 base, 1 length, 2 attr {7 lock, 2 nonidem, 1 cached, 0 exec}, 3 reserved
//   lkp_*                     lookup request (valid/ready, address, tag)
//   rsp_*                     lookup response (valid/ready, tag, hit, region, exec, cached, nonidem)
module cva6_pma_table #(
    parameter int NrRegions = 4,
    parameter int AddrWidth = 64,
    parameter int IdWidth = 4,
    localparam int CfgAw = $clog2(NrRegions) + 2,
    localparam int RegW = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [CfgAw-1:0]     cfg_addr_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lkp_valid_i,
    output logic                 lkp_ready_o,
    input  logic [AddrWidth-1:0] lkp_addr_i,
    input  logic [IdWidth-1:0]   lkp_id_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IdWidth-1:0]   rsp_id_o,
    output logic                 rsp_hit_o,
    output logic [RegW-1:0]      rsp_region_o,
    output logic                 rsp_exec_o,
    output logic                 rsp_cached_o,
    output logic                 rsp_nonidem_o
);
    logic [AddrWidth-1:0] base [NrRegions];
    logic [AddrWidth-1:0] len [NrRegions];
    logic [3:0]           attr [NrRegions];
    logic [CfgAw-1:0]     cfgRegionFull;
    logic [RegW-1:0]      cfgRegion;
    logic [1:0]           cfgField;
    logic                 cfgInRange, cfgLocked, cfgWrOk;
    logic [AddrWidth-1:0] cfgRdVal;
    logic                 s1Valid, s2Free;
    logic [AddrWidth-1:0] s1Addr;
    logic [IdWidth-1:0]   s1Id;
    logic                 mHit;
    logic [RegW-1:0]      mRegion;
    logic [2:0]           mAttr;

    assign cfgField      = cfg_addr_i[1:0];
    assign cfgRegionFull = cfg_addr_i >> 2;
    assign cfgRegion     = RegW'(cfgRegionFull);
    assign cfgInRange    = 32'(cfgRegionFull) < NrRegions;
    assign cfgLocked     = cfgInRange && attr[cfgRegion][3];
    assign cfgWrOk       = cfgInRange && !cfgLocked && cfgField != 2'd3;
    assign cfgRdVal      = !cfgInRange ? '0 :
                           cfgField == 2'd0 ? base[cfgRegion] :
                           cfgField == 2'd1 ? len[cfgRegion] :
                           cfgField == 2'd2 ? AddrWidth'({attr[cfgRegion][3], 4'b0, attr[cfgRegion][2:0]}) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrRegions; i++) begin
                base[i] <= '0;
                len[i]  <= '0;
                attr[i] <= '0;
            end
        end else if (cfg_req_i && cfg_we_i && cfgWrOk) begin
            if (cfgField == 2'd0) base[cfgRegion] <= cfg_wdata_i;
            if (cfgField == 2'd1) len[cfgRegion] <= cfg_wdata_i;
            if (cfgField == 2'd2) attr[cfgRegion] <= {cfg_wdata_i[7], cfg_wdata_i[2:0]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_rvalid_o <= 1'b0;
            cfg_err_o    <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i && !cfg_we_i;
            cfg_err_o    <= cfg_req_i && (cfg_we_i ? !cfgWrOk : !cfgInRange);
            if (cfg_req_i && !cfg_we_i) cfg_rdata_o <= cfgRdVal;
        end
    end

    // Walk downwards so the lowest matching index is the last one written.
    // The subtraction only matters when addr >= base, so it never wraps.
    always_comb begin
        mHit    = 1'b0;
        mRegion = '0;
        mAttr   = 3'b100;
        for (int i = NrRegions - 1; i >= 0; i--) begin
            if (len[i] != '0 && s1Addr >= base[i] && (s1Addr - base[i]) < len[i]) begin
                mHit    = 1'b1;
                mRegion = RegW'(i);
                mAttr   = attr[i][2:0];
            end
        end
    end

    assign s2Free      = !rsp_valid_o || rsp_ready_i;
    assign lkp_ready_o = !s1Valid || s2Free;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1Valid       <= 1'b0;
            s1Addr        <= '0;
            s1Id          <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_id_o      <= '0;
            rsp_hit_o     <= 1'b0;
            rsp_region_o  <= '0;
            rsp_exec_o    <= 1'b0;
            rsp_cached_o  <= 1'b0;
            rsp_nonidem_o <= 1'b0;
        end else begin
            if (lkp_valid_i && lkp_ready_o) begin
                s1Valid <= 1'b1;
                s1Addr  <= lkp_addr_i;
                s1Id    <= lkp_id_i;
            end else if (s2Free) begin
                s1Valid <= 1'b0;
            end
            if (s2Free) rsp_valid_o <= s1Valid;
            if (s1Valid && s2Free) begin
                rsp_id_o      <= s1Id;
                rsp_hit_o     <= mHit;
                rsp_region_o  <= mRegion;
                rsp_exec_o    <= mAttr[0];
                rsp_cached_o  <= mAttr[1];
                rsp_nonidem_o <= mAttr[2];
            end
        end
    end
endmodule

// File: tb/tb_cva6_pma_table.sv
// tb_cva6_pma_table: directed self-checking bench for cva6_pma_table
module tb_cva6_pma_table;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_req_i, cfg_we_i;
    logic [3:0]  cfg_addr_i;
    logic [63:0] cfg_wdata_i;
    logic        cfg_rvalid_o, cfg_err_o;
    logic [63:0] cfg_rdata_o;
    logic        lkp_valid_i, lkp_ready_o;
    logic [63:0] lkp_addr_i;
    logic [3:0]  lkp_id_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [3:0]  rsp_id_o;
    logic        rsp_hit_o;
    logic [1:0]  rsp_region_o;
    logic        rsp_exec_o, rsp_cached_o, rsp_nonidem_o;
    int          compared = 0;
    int          mismatched = 0;
    int          sent, got, cyc;
    logic        doSend, doGot;

    cva6_pma_table #(.NrRegions(4), .AddrWidth(64), .IdWidth(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
        .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_addr_i(lkp_addr_i), .lkp_id_i(lkp_id_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o), .rsp_hit_o(rsp_hit_o),
        .rsp_region_o(rsp_region_o), .rsp_exec_o(rsp_exec_o), .rsp_cached_o(rsp_cached_o),
        .rsp_nonidem_o(rsp_nonidem_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfgWrite(input logic [3:0] a, input logic [63:0] d, input logic expErr);
        cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
        @(posedge clk_i); #1;
        cfg_req_i = 1'b0; cfg_we_i = 1'b0;
        chk("wr_err", cfg_err_o, expErr);
    endtask

    task automatic cfgRead(input logic [3:0] a, input logic [63:0] expData);
        cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = a;
        @(posedge clk_i); #1;
        cfg_req_i = 1'b0;
        chk("rd_valid", cfg_rvalid_o, 1'b1);
        chk("rd_data", cfg_rdata_o, expData);
        chk("rd_err", cfg_err_o, 1'b0);
    endtask

    task automatic lookup(input logic [63:0] a, input logic [3:0] id, input logic h, input logic [1:0] r,
                          input logic e, input logic c, input logic n);
        lkp_valid_i = 1'b1; lkp_addr_i = a; lkp_id_i = id; rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        lkp_valid_i = 1'b0;
        chk("lat_early", rsp_valid_o, 1'b0);
        @(posedge clk_i); #1;
        chk("rsp_valid", rsp_valid_o, 1'b1);
        chk("rsp_id", rsp_id_o, id);
        chk("rsp_hit", rsp_hit_o, h);
        chk("rsp_region", rsp_region_o, r);
        chk("rsp_exec", rsp_exec_o, e);
        chk("rsp_cached", rsp_cached_o, c);
        chk("rsp_nonidem", rsp_nonidem_o, n);
        @(posedge clk_i); #1;
    endtask

    function automatic logic [63:0] streamAddr(input int k);
        return (k == 7) ? 64'h9000 : (k % 2 == 1) ? 64'h2800 : 64'h1800;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
        lkp_valid_i = 1'b0; lkp_addr_i = '0; lkp_id_i = '0; rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_lkp_ready", lkp_ready_o, 1'b1);
        chk("rst_cfg_rvalid", cfg_rvalid_o, 1'b0);
        chk("rst_cfg_err", cfg_err_o, 1'b0);
        chk("rst_nonidem", rsp_nonidem_o, 1'b0);
        lookup(64'h8000_0000, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        cfgRead(4'd0, 64'h0);
        cfgRead(4'd6, 64'h0);
        cfgRead(4'd13, 64'h0);

        cfgWrite(4'd0, 64'h1000_0000, 1'b0);
        cfgWrite(4'd1, 64'h7000_0000, 1'b0);
        cfgWrite(4'd2, 64'h3, 1'b0);
        cfgRead(4'd1, 64'h7000_0000);
        lookup(64'h1000_0000, 4'h2, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
        lookup(64'h7FFF_FFFF, 4'h3, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
        lookup(64'h8000_0000, 4'h4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        lookup(64'h0FFF_FFFF, 4'h5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        cfgWrite(4'd0, 64'h0, 1'b0);
        cfgWrite(4'd1, 64'h2000, 1'b0);
        cfgWrite(4'd2, 64'h1, 1'b0);
        cfgWrite(4'd4, 64'h1000, 1'b0);
        cfgWrite(4'd5, 64'h2000, 1'b0);
        cfgWrite(4'd6, 64'hFFFF_FF74, 1'b0);
        cfgRead(4'd6, 64'h4);
        lookup(64'h1800, 4'h6, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        lookup(64'h2800, 4'h7, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        lookup(64'h3000, 4'h8, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        sent = 0; got = 0; cyc = 0;
        lkp_valid_i = 1'b1; lkp_addr_i = streamAddr(0); lkp_id_i = 4'd0;
        while (got < 8 && cyc < 300) begin
            rsp_ready_i = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            if (cyc == 2) chk("full_lkp_ready", lkp_ready_o, 1'b0);
            if (rsp_valid_o) begin
                chk("s_id", rsp_id_o, 64'(got));
                chk("s_hit", rsp_hit_o, got != 7);
                chk("s_region", rsp_region_o, (got != 7 && got % 2 == 1) ? 2'd1 : 2'd0);
                chk("s_exec", rsp_exec_o, got != 7 && got % 2 == 0);
                chk("s_cached", rsp_cached_o, 1'b0);
                chk("s_nonidem", rsp_nonidem_o, got == 7 || got % 2 == 1);
            end
            doSend = lkp_valid_i && lkp_ready_o;
            doGot = rsp_valid_o && rsp_ready_i;
            @(posedge clk_i); #1;
            if (doGot) got++;
            if (doSend) begin
                sent++;
                if (sent < 8) begin
                    lkp_addr_i = streamAddr(sent);
                    lkp_id_i = 4'(sent);
                end else lkp_valid_i = 1'b0;
            end
            cyc++;
        end
        chk("stream_count", 64'(got), 64'd8);
        chk("stream_drained", rsp_valid_o, 1'b0);
        rsp_ready_i = 1'b1;

        cfgWrite(4'd10, 64'h81, 1'b0);
        cfgWrite(4'd8, 64'h5000, 1'b1);
        cfgRead(4'd8, 64'h0);
        cfgRead(4'd10, 64'h81);
        cfgWrite(4'd10, 64'h0, 1'b1);
        cfgRead(4'd10, 64'h81);
        cfgWrite(4'd3, 64'hDEAD, 1'b1);
        cfgRead(4'd3, 64'h0);

        rsp_ready_i = 1'b0;
        lkp_valid_i = 1'b1; lkp_addr_i = 64'h0; lkp_id_i = 4'h5;
        @(posedge clk_i); #1;
        lkp_valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("pre_rst_valid", rsp_valid_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_valid", rsp_valid_o, 1'b0);
        chk("async_rst_ready", lkp_ready_o, 1'b1);
        @(posedge clk_i); #1;
        rst_i = 1'b0; rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("dropped", rsp_valid_o, 1'b0);
        cfgWrite(4'd8, 64'h5000, 1'b0);
        cfgRead(4'd8, 64'h5000);
        cfgRead(4'd10, 64'h0);

        lookup(64'h10, 4'h9, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = 4'd13; cfg_wdata_i = 64'h100;
        lkp_valid_i = 1'b1; lkp_addr_i = 64'h10; lkp_id_i = 4'hA;
        @(posedge clk_i); #1;
        cfg_req_i = 1'b0; cfg_we_i = 1'b0; lkp_valid_i = 1'b0;
        chk("race_err", cfg_err_o, 1'b0);
        @(posedge clk_i); #1;
        chk("race_valid", rsp_valid_o, 1'b1);
        chk("race_id", rsp_id_o, 4'hA);
        chk("race_hit", rsp_hit_o, 1'b1);
        chk("race_region", rsp_region_o, 2'd3);
        chk("race_nonidem", rsp_nonidem_o, 1'b0);
        @(posedge clk_i); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
